seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised sequential shift-add multiplier, the next generation of the 32-bit unsigned PA1 multiplier. It supports any operand width and a per-operation signed/unsigned mode, and keeps the run/ready handshake. It computes WIDTH×WIDTH→2·WIDTH in one add-or-skip and shift-right step per cycle, then applies a sign fix-up when needed. It sits beside the ALU as the multi-cycle multiply unit.

## Interface
- WIDTH, 32, operand width; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), localparam, iteration counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  start request; sampled only in IDLE or DONE.
- sgn  in  1  1 = two's-complement operands, 0 = unsigned; sampled with run.
- mcand  in  WIDTH  multiplicand; sampled with run.
- mplier  in  WIDTH  multiplier; sampled with run.
- prod  out  2·WIDTH  product register.
- rdy  out  1  result valid; level, held until the next accepted run.
- busy  out  1  high in CALC and FIX.

## Operation
- FSM states:
  - IDLE –run→ CALC.
  - CALC –cnt==0 (or early exit)→ FIX if neg, else DONE.
  - FIX → DONE.
  - DONE –run→ CALC.
- Load, on an accepted run:
  - M ← |mcand|; prod ← {0, |mplier|}.
  - Magnitudes are taken only when sgn=1 and the operand MSB is 1.
  - neg ← sgn & (mcand[W-1] ^ mplier[W-1]).
  - cnt ← WIDTH; rdy ← 0.
- Magnitude of −2^(W-1) is 2^(W-1), which fits unsigned in WIDTH bits.
- CALC step:
  - If prod[0]=1, {c,hi} = prod[2W-1:W] + M, computed at W+1 bits; else {c,hi} = {0, prod[2W-1:W]}.
  - prod ← {c, hi, prod[W-1:1]}; cnt ← cnt−1.
- FIX: prod ← −prod, two's complement at 2·WIDTH bits.
- DONE: rdy=1, prod holds the result.
- run while busy is ignored; operands are not re-sampled.
- run in DONE restarts with the same cycle timing as from IDLE.
- Reset values: state=IDLE; prod=0; rdy=0; busy=0; cnt=0; M=0; neg=0.
- Reset mid-operation aborts immediately; there is no partial result.

## Timing
- Cycle 0: run sampled high, load occurs.
- Cycles 1..WIDTH: CALC steps.
- Unsigned, or signed with a non-negative result: rdy=1 and prod valid from cycle WIDTH+1.
- Negative signed result: FIX at cycle WIDTH+1; rdy from cycle WIDTH+2.
- busy falls in the same cycle rdy rises.
- A run held high in DONE starts a new operation in the next cycle, and rdy drops at that edge.

## Configuration
- SEQ_MULT_EARLY_EXIT_EN defined:
  - Each CALC cycle, before the add, check whether the unconsumed multiplier bits are all zero, i.e. prod[W-1:0] masked to the low cnt bits == 0.
  - If so: prod ← prod >> cnt, cnt ← 0, then go to FIX or DONE.
  - Latency becomes data-dependent: mplier=0 gives rdy at cycle 2; mplier=1 gives rdy at cycle 3 (unsigned).
- SEQ_MULT_EARLY_EXIT_EN undefined: always exactly WIDTH CALC cycles; the variable shifter is not built.
- Results are identical in both builds.

## Structure
- Package seq_mult_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE) with a fixed 2-bit encoding;
  - the WIDTH bounds constants.
- One sub-module, seq_mult_addu: WIDTH-bit unsigned adder with carry-out, replacing the ALU addu path.
- Everything else stays in one always_ff plus one always_comb.

## Test plan
- WIDTH=32, unsigned, 0xFFFFFFFF × 0xFFFFFFFF → prod=0xFFFFFFFE00000001, rdy at cycle 33, busy high cycles 1..32.
- WIDTH=32, signed, −7 × 3 → prod=0xFFFFFFFFFFFFFFEB, rdy at cycle 34; signed −1 × −1 → 0x1, rdy at cycle 33.
- WIDTH=32, signed, 0x80000000 × 0x80000000 → 0x4000000000000000; signed 0x80000000 × 1 → 0xFFFFFFFF80000000.
- WIDTH=8, unsigned, 0xFF × 0xFF → 0xFE01, rdy at cycle 9; during busy, run with new operands → ignored, result unchanged.
- rst low at cycle 10 of a 32-bit operation → prod=0, rdy=0, busy=0 immediately; a new run after release → correct result at nominal latency.
- SEQ_MULT_EARLY_EXIT_EN defined, unsigned 5 × 0 → prod=0, rdy at cycle 2; 0x1234 × 0x3 → 0x369C, rdy at cycle 4.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_mult_addu.sv
// WIDTH-bit unsigned adder with carry-out, used for the add step of the multiplier.
module seq_mult_addu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_co
);

  assign {o_co, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add WIDTH x WIDTH -> 2*WIDTH multiplier, signed or unsigned per operation.
// Optional data-dependent early exit: define SEQ_MULT_EARLY_EXIT_EN.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] prod,
  output logic               rdy,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("seq_multiplier: WIDTH out of range");
  end

  state_t             r_state;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_m;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic               r_rdy;
  logic               r_busy;

  logic [WIDTH-1:0]   w_mcand_mag;
  logic [WIDTH-1:0]   w_mplier_mag;
  logic [WIDTH-1:0]   w_sum;
  logic               w_co;
  logic [WIDTH:0]     w_hi_c;
  logic [2*WIDTH-1:0] w_calc_prod;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_calc_last;

  seq_mult_addu #(.WIDTH(WIDTH)) u_addu (
    .i_a   (r_prod[2*WIDTH-1:WIDTH]),
    .i_b   (r_m),
    .o_sum (w_sum),
    .o_co  (w_co)
  );

`ifdef SEQ_MULT_EARLY_EXIT_EN
  // Mask selecting the multiplier bits not yet consumed (low r_cnt bits).
  logic [WIDTH:0]   w_one_sh;
  logic [WIDTH-1:0] w_mask;
  assign w_one_sh = (WIDTH + 1)'(1) << r_cnt;
  assign w_mask   = WIDTH'(w_one_sh - (WIDTH + 1)'(1));
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_mcand_mag  = (sgn && mcand[WIDTH-1])  ? -mcand  : mcand;
    w_mplier_mag = (sgn && mplier[WIDTH-1]) ? -mplier : mplier;
    w_hi_c       = r_prod[0] ? {w_co, w_sum} : {1'b0, r_prod[2*WIDTH-1:WIDTH]};
    w_calc_prod  = {w_hi_c, r_prod[WIDTH-1:1]};
    w_cnt_nxt    = r_cnt - CNT_W'(1);
    w_calc_last  = (r_cnt == CNT_W'(1));
`ifdef SEQ_MULT_EARLY_EXIT_EN
    if ((r_prod[WIDTH-1:0] & w_mask) == '0) begin
      w_calc_prod = r_prod >> r_cnt;
      w_cnt_nxt   = '0;
      w_calc_last = 1'b1;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_prod  <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (run) begin
            r_m     <= w_mcand_mag;
            r_prod  <= {{WIDTH{1'b0}}, w_mplier_mag};
            r_neg   <= sgn & (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
            r_cnt   <= CNT_W'(WIDTH);
            r_rdy   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_prod <= w_calc_prod;
          r_cnt  <= w_cnt_nxt;
          if (w_calc_last) begin
            if (r_neg) begin
              r_state <= FIX;
            end else begin
              r_state <= DONE;
              r_rdy   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        FIX: begin
          r_prod  <= -r_prod;
          r_state <= DONE;
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign prod = r_prod;
  assign rdy  = r_rdy;
  assign busy = r_busy;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: 32-bit and 8-bit instances, directed vectors.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        run32 = 1'b0, sgn32 = 1'b0;
  logic [31:0] mcand32 = '0, mplier32 = '0;
  logic [63:0] prod32;
  logic        rdy32, busy32;

  logic        run8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  mcand8 = '0, mplier8 = '0;
  logic [15:0] prod8;
  logic        rdy8, busy8;

  seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .run(run32), .sgn(sgn32), .mcand(mcand32), .mplier(mplier32),
    .prod(prod32), .rdy(rdy32), .busy(busy32)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .run(run8), .sgn(sgn8), .mcand(mcand8), .mplier(mplier8),
    .prod(prod8), .rdy(rdy8), .busy(busy8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [63:0] prod;
    int          at;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   checks = 0;
  int   errors = 0;
  logic prev32 = 1'b0;
  logic prev8  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Edges from the load edge until rdy is seen high.
  function automatic int exp_lat(input int w, input bit s, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask;
    logic [63:0] mag;
    bit          neg;
    int          steps;
    mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    neg   = s && (a[w-1] ^ b[w-1]);
    mag   = (s && b[w-1]) ? ((~b + 64'd1) & mask) : (b & mask);
    steps = w;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    begin
      int k;
      k = 0;
      for (int i = 0; i < w; i++) if (mag[i]) k = i + 1;
      steps = (k == w) ? w : k + 1;
    end
`else
    if (mag == 64'd0 && mag != 64'd0) steps = 0;
`endif
    return steps + (neg ? 1 : 0);
  endfunction

  // Monitors: pop and compare on each rising edge of rdy.
  always @(negedge clk) begin : mon32
    exp_t e;
    if (rst && rdy32 && !prev32) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdy32_unexpected: got rdy=1 expected no pending op");
      end else begin
        e = q32.pop_front();
        check("prod32", prod32, e.prod);
        check("lat32", 64'(cyc), 64'(e.at));
        check("busy32_at_rdy", 64'(busy32), 64'd0);
      end
    end
    prev32 = rdy32;
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst && rdy8 && !prev8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdy8_unexpected: got rdy=1 expected no pending op");
      end else begin
        e = q8.pop_front();
        check("prod8", 64'(prod8), e.prod);
        check("lat8", 64'(cyc), 64'(e.at));
        check("busy8_at_rdy", 64'(busy8), 64'd0);
      end
    end
    prev8 = rdy8;
  end

  task automatic op(input int w, input bit s, input logic [63:0] a, input logic [63:0] b,
                    input logic [63:0] expp, input bit poke_run);
    exp_t e;
    int   n;
    int   bad;
    logic is_busy, is_rdy;
    @(negedge clk);
    if (w == 32) begin
      sgn32 = s; mcand32 = a[31:0]; mplier32 = b[31:0]; run32 = 1'b1;
    end else begin
      sgn8 = s; mcand8 = a[7:0]; mplier8 = b[7:0]; run8 = 1'b1;
    end
    @(posedge clk);
    #1;
    run32 = 1'b0;
    run8  = 1'b0;
    e.prod = expp;
    e.at   = cyc + exp_lat(w, s, a, b);
    if (w == 32) q32.push_back(e); else q8.push_back(e);
    check($sformatf("rdy%0d_low_after_load", w), 64'(w == 32 ? rdy32 : rdy8), 64'd0);
    check($sformatf("busy%0d_after_load", w), 64'(w == 32 ? busy32 : busy8), 64'd1);
    n = 0;
    bad = 0;
    forever begin
      @(negedge clk);
      #1;
      if ((w == 32 ? q32.size() : q8.size()) == 0) break;
      is_busy = (w == 32) ? busy32 : busy8;
      is_rdy  = (w == 32) ? rdy32 : rdy8;
      if (!is_busy || is_rdy) bad++;
      n++;
      if (poke_run && n == 3) begin
        sgn8 = 1'b0; mcand8 = 8'h02; mplier8 = 8'h03; run8 = 1'b1;
      end
      if (n == 4) run8 = 1'b0;
      if (n > 200) break;
    end
    if ((w == 32 ? q32.size() : q8.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout%0d: got no rdy expected rdy within 200 cycles", w);
      if (w == 32) q32.delete(); else q8.delete();
    end
    check($sformatf("busy%0d_window", w), 64'(bad), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    check("reset_prod32", prod32, 64'd0);
    check("reset_rdy32", 64'(rdy32), 64'd0);
    check("reset_busy32", 64'(busy32), 64'd0);
    check("reset_prod8", 64'(prod8), 64'd0);
    check("reset_rdy8", 64'(rdy8), 64'd0);
    check("reset_busy8", 64'(busy8), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    op(32, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    op(32, 1'b1, 64'hFFFF_FFF9, 64'h0000_0003, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    op(32, 1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    op(32, 1'b1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    op(32, 1'b1, 64'h8000_0000, 64'h0000_0001, 64'hFFFF_FFFF_8000_0000, 1'b0);
    op(32, 1'b0, 64'h0000_0005, 64'h0000_0000, 64'h0, 1'b0);
    op(32, 1'b0, 64'h0000_1234, 64'h0000_0003, 64'h0000_369C, 1'b0);
    op(32, 1'b0, 64'h8000_0000, 64'h0000_0002, 64'h1_0000_0000, 1'b0);
    op(32, 1'b1, 64'hFFFF_FFFB, 64'h0000_0000, 64'h0, 1'b0);
    op(32, 1'b1, 64'h0000_0007, 64'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0);
    op(32, 1'b0, 64'h0001_0000, 64'h0001_0000, 64'h1_0000_0000, 1'b0);

    op(8, 1'b0, 64'hFF, 64'hFF, 64'hFE01, 1'b1);
    repeat (3) @(negedge clk);
    check("hold_prod8", 64'(prod8), 64'hFE01);
    check("hold_rdy8", 64'(rdy8), 64'd1);
    op(8, 1'b1, 64'h80, 64'h7F, 64'hC080, 1'b0);

    // Abort a 32-bit operation in its tenth cycle.
    @(negedge clk);
    sgn32 = 1'b0; mcand32 = 32'hFFFF_FFFF; mplier32 = 32'hFFFF_FFFF; run32 = 1'b1;
    @(posedge clk);
    #1;
    run32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy32_before_reset", 64'(busy32), 64'd1);
    rst = 1'b0;
    #1;
    check("abort_prod32", prod32, 64'd0);
    check("abort_rdy32", 64'(rdy32), 64'd0);
    check("abort_busy32", 64'(busy32), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    op(32, 1'b0, 64'h0000_1234, 64'h0000_0003, 64'h0000_369C, 1'b0);
    op(32, 1'b1, 64'hFFFF_FFF9, 64'h0000_0003, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);

    repeat (4) @(negedge clk);
    check("pending32_at_end", 64'(q32.size()), 64'd0);
    check("pending8_at_end", 64'(q8.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
